// File: rtl/icache_direct_mapped_if.sv
// icache_direct_mapped_if: core fetch port and memory refill bus of the instruction cache
interface icache_direct_mapped_if;
  logic [31:0] pc;
  logic        inst_read_enable;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_wait_req;
  logic        invalidate;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_wait_req;
  logic [31:0] mem_read_data;
  logic        mem_valid;
  modport slave (
    input  pc, inst_read_enable, invalidate, mem_wait_req, mem_read_data, mem_valid,
    output inst, inst_valid, inst_wait_req, mem_address, mem_read_enable
  );
  modport master (
    output pc, inst_read_enable, invalidate, mem_wait_req, mem_read_data, mem_valid,
    input  inst, inst_valid, inst_wait_req, mem_address, mem_read_enable
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with same-cycle hits and word-by-word line refill
module icache_direct_mapped #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input logic                  clock,
  input logic                  reset,
  icache_direct_mapped_if.slave bus
);
  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 32 - IDX - OFF - 2;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t           r_state, w_next;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tags [LINES];
  logic [31:0]      r_data [LINES][WORDS_PER_LINE];
  logic [TW-1:0]    r_tag;
  logic [IDX-1:0]   r_idx;
  logic [OFF-1:0]   r_cnt;
  logic             r_pinv;
  logic [IDX-1:0]   w_idx;
  logic [OFF-1:0]   w_off;
  logic [TW-1:0]    w_tag;
  logic             w_hit, w_miss, w_last;
  assign w_idx  = bus.pc[IDX+OFF+1:OFF+2];
  assign w_off  = bus.pc[OFF+1:2];
  assign w_tag  = bus.pc[31:IDX+OFF+2];
  assign w_hit  = r_valid[w_idx] && r_tags[w_idx] == w_tag;
  assign w_miss = r_state == IDLE && bus.inst_read_enable && !w_hit;
  assign w_last = r_state == RESP && bus.mem_valid && r_cnt == OFF'(WORDS_PER_LINE - 1);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_miss ? REQ : IDLE) :
             (r_state == REQ)  ? (bus.mem_wait_req ? REQ : RESP) :
             (!bus.mem_valid   ? RESP : (w_last ? IDLE : REQ));
  end
  assign bus.inst_valid      = r_state == IDLE && bus.inst_read_enable && w_hit;
  assign bus.inst            = bus.inst_valid ? r_data[w_idx][w_off] : '0;
  assign bus.inst_wait_req   = r_state != IDLE || w_miss;
  assign bus.mem_read_enable = r_state == REQ;
  // the word counter replaces the offset field, so refill addresses never carry out of the line
  assign bus.mem_address     = {r_tag, r_idx, r_cnt, 2'b00};
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pinv  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_tag <= w_tag;
        r_idx <= w_idx;
        r_cnt <= '0;
      end
      if (r_state == RESP && bus.mem_valid) begin
        r_data[r_idx][r_cnt] <= bus.mem_read_data;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_tags[r_idx]  <= r_tag;
        r_valid[r_idx] <= !r_pinv;
      end
      if (bus.invalidate) r_valid <= '0;
      // an invalidate during a refill keeps that line from becoming valid
      r_pinv <= !w_last && (r_pinv || (bus.invalidate && r_state != IDLE));
    end
  end
endmodule
